// File: rtl/adma_pkg.sv
// Shared types and helpers for the ADMA read-side blocks.
package adma_pkg;

    // Default request field widths; the request struct is built on these.
    localparam int ADMA_SRC_ADDR_W = 32;
    localparam int ADMA_MST_ID_W   = 5;
    localparam int ADMA_ATX_LEN_W  = 8;

    // One read request as presented by a channel and held in the output stage.
    typedef struct packed {
        logic [ADMA_MST_ID_W-1:0]   id;
        logic [ADMA_SRC_ADDR_W-1:0] addr;
        logic [ADMA_ATX_LEN_W-1:0]  len;
        logic [1:0]                 burst;
    } rd_req_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chn_num_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adma_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping upward, and moves the pointer just past the winner.
module adma_rr_arb #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] gnt_idx_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;
    logic         found;
    int           idx;

    // Search upward from the pointer with wrap; grant only when enabled.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                gnt_idx_o = W'(idx);
            end
        end
        if (en_i && found) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    // Pointer advances past the winner only when a grant is actually issued.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i && found) begin
            ptr_d = (gnt_idx_o == W'(N - 1)) ? '0 : gnt_idx_o + W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adma_dm_rd_sched.sv
// Read-transaction scheduler: round-robin over channel requests, one
// registered output stage, per-channel and global outstanding limits.
module adma_dm_rd_sched
    import adma_pkg::*;
#(
    parameter int DMA_CHN_NUM   = 4,
    parameter int SRC_ADDR_W    = ADMA_SRC_ADDR_W,
    parameter int MST_ID_W      = ADMA_MST_ID_W,
    parameter int ATX_LEN_W     = ADMA_ATX_LEN_W,
    parameter int ATX_NUM_OSTD  = DMA_CHN_NUM,
    parameter int CHN_OSTD_MAX  = 2,
    parameter int DMA_CHN_NUM_W = chn_num_w(DMA_CHN_NUM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [MST_ID_W-1:0]      chn_arid    [0:DMA_CHN_NUM-1],
    input  logic [SRC_ADDR_W-1:0]    chn_araddr  [0:DMA_CHN_NUM-1],
    input  logic [ATX_LEN_W-1:0]     chn_arlen   [0:DMA_CHN_NUM-1],
    input  logic [1:0]               chn_arburst [0:DMA_CHN_NUM-1],
    input  logic                     chn_ar_vld  [0:DMA_CHN_NUM-1],
    output logic                     chn_ar_rdy  [0:DMA_CHN_NUM-1],
    input  logic                     chn_cpl     [0:DMA_CHN_NUM-1],
    output logic                     chn_idle    [0:DMA_CHN_NUM-1],
    output logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
    output logic [MST_ID_W-1:0]      atx_arid,
    output logic [SRC_ADDR_W-1:0]    atx_araddr,
    output logic [ATX_LEN_W-1:0]     atx_arlen,
    output logic [1:0]               atx_arburst,
    output logic                     atx_vld,
    input  logic                     atx_rdy,
    output logic                     ostd_err
);

    localparam int CW = $clog2(CHN_OSTD_MAX + 1);
    localparam int GW = $clog2(ATX_NUM_OSTD + 1);

    logic [CW-1:0]            ostd_q [DMA_CHN_NUM];
    logic [CW-1:0]            ostd_d [DMA_CHN_NUM];
    logic [GW-1:0]            gbl_q;
    logic [GW-1:0]            gbl_d;
    logic                     err_q;
    logic                     err_d;
    rd_req_t                  out_q;
    rd_req_t                  out_d;
    logic                     vld_q;
    logic                     vld_d;
    logic [DMA_CHN_NUM_W-1:0] chn_q;
    logic [DMA_CHN_NUM_W-1:0] chn_d;

    logic [DMA_CHN_NUM-1:0]   elig;
    logic [DMA_CHN_NUM-1:0]   gnt;
    logic [DMA_CHN_NUM_W-1:0] gnt_idx;
    logic                     load;
    logic                     any_gnt;

    // A channel may win only if it and the whole block are below their limits.
    always_comb begin
        elig = '0;
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            elig[c] = chn_ar_vld[c]
                   && (ostd_q[c] < CW'(CHN_OSTD_MAX))
                   && (gbl_q < GW'(ATX_NUM_OSTD));
        end
    end

    // The stage can take a new transaction when empty or draining this cycle.
    always_comb begin
        load    = !vld_q || atx_rdy;
        any_gnt = |gnt;
    end

    adma_rr_arb #(
        .N (DMA_CHN_NUM),
        .W (DMA_CHN_NUM_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (elig),
        .en_i      (load),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Per-channel handshake and idle status straight from grant and counters.
    always_comb begin
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            chn_ar_rdy[c] = gnt[c];
            chn_idle[c]   = (ostd_q[c] == '0);
        end
    end

    // Outstanding bookkeeping: count on grant, release on completion, flag
    // completions that arrive with nothing outstanding.
    always_comb begin
        gbl_d = gbl_q;
        err_d = err_q;
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            ostd_d[c] = ostd_q[c];
            if (chn_cpl[c]) begin
                if (ostd_q[c] == '0) begin
                    err_d = 1'b1;
                end else begin
                    ostd_d[c] = ostd_d[c] - CW'(1);
                    gbl_d     = gbl_d - GW'(1);
                end
            end
            if (gnt[c]) begin
                ostd_d[c] = ostd_d[c] + CW'(1);
                gbl_d     = gbl_d + GW'(1);
            end
        end
    end

    // Output stage: capture the winner on load, otherwise hold the fields.
    always_comb begin
        vld_d = vld_q;
        out_d = out_q;
        chn_d = chn_q;
        if (load) begin
            vld_d = any_gnt;
            if (any_gnt) begin
                chn_d = gnt_idx;
                for (int c = 0; c < DMA_CHN_NUM; c++) begin
                    if (gnt[c]) begin
                        out_d.id    = chn_arid[c];
                        out_d.addr  = chn_araddr[c];
                        out_d.len   = chn_arlen[c];
                        out_d.burst = chn_arburst[c];
                    end
                end
            end
        end
    end

    // State registers; reset drops all bookkeeping at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < DMA_CHN_NUM; c++) begin
                ostd_q[c] <= '0;
            end
            gbl_q <= '0;
            err_q <= 1'b0;
            out_q <= '0;
            vld_q <= 1'b0;
            chn_q <= '0;
        end else begin
            for (int c = 0; c < DMA_CHN_NUM; c++) begin
                ostd_q[c] <= ostd_d[c];
            end
            gbl_q <= gbl_d;
            err_q <= err_d;
            out_q <= out_d;
            vld_q <= vld_d;
            chn_q <= chn_d;
        end
    end

    // Transaction port driven directly from the output stage.
    always_comb begin
        atx_vld     = vld_q;
        atx_chn_id  = chn_q;
        atx_arid    = out_q.id;
        atx_araddr  = out_q.addr;
        atx_arlen   = out_q.len;
        atx_arburst = out_q.burst;
        ostd_err    = err_q;
    end

endmodule

// File: tb/tb_adma_dm_rd_sched.sv
// Bench for adma_dm_rd_sched: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue-free
// behavioural model of the scheduler.
module tb_adma_dm_rd_sched;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int IW   = 5;
    localparam int LW   = 8;
    localparam int GOST = 4;
    localparam int COST = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] chn_arid    [0:N-1];
    logic [AW-1:0] chn_araddr  [0:N-1];
    logic [LW-1:0] chn_arlen   [0:N-1];
    logic [1:0]    chn_arburst [0:N-1];
    logic          chn_ar_vld  [0:N-1];
    logic          chn_ar_rdy  [0:N-1];
    logic          chn_cpl     [0:N-1];
    logic          chn_idle    [0:N-1];
    logic [1:0]    atx_chn_id;
    logic [IW-1:0] atx_arid;
    logic [AW-1:0] atx_araddr;
    logic [LW-1:0] atx_arlen;
    logic [1:0]    atx_arburst;
    logic          atx_vld;
    logic          atx_rdy = 1'b0;
    logic          ostd_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: counts, pointer and the transaction on the port.
    int            mOstd [N];
    int            mGbl;
    int            mRr;
    bit            mVld;
    bit            mErr;
    int            mChn;
    logic [IW-1:0] mId;
    logic [AW-1:0] mAddr;
    logic [LW-1:0] mLen;
    logic [1:0]    mBurst;

    always #5 clk = ~clk;

    adma_dm_rd_sched #(
        .DMA_CHN_NUM  (N),
        .SRC_ADDR_W   (AW),
        .MST_ID_W     (IW),
        .ATX_LEN_W    (LW),
        .ATX_NUM_OSTD (GOST),
        .CHN_OSTD_MAX (COST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .chn_arid    (chn_arid),
        .chn_araddr  (chn_araddr),
        .chn_arlen   (chn_arlen),
        .chn_arburst (chn_arburst),
        .chn_ar_vld  (chn_ar_vld),
        .chn_ar_rdy  (chn_ar_rdy),
        .chn_cpl     (chn_cpl),
        .chn_idle    (chn_idle),
        .atx_chn_id  (atx_chn_id),
        .atx_arid    (atx_arid),
        .atx_araddr  (atx_araddr),
        .atx_arlen   (atx_arlen),
        .atx_arburst (atx_arburst),
        .atx_vld     (atx_vld),
        .atx_rdy     (atx_rdy),
        .ostd_err    (ostd_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] packRdy();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = chn_ar_rdy[c];
        return v;
    endfunction

    function automatic logic [N-1:0] packIdle();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = chn_idle[c];
        return v;
    endfunction

    // Drive one cycle of request/completion/ready, just after the clock edge.
    task automatic applyStimulus(input logic [N-1:0] vld, input logic [N-1:0] cpl, input logic rdy);
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            chn_ar_vld[c] = vld[c];
            chn_cpl[c]    = cpl[c];
        end
        atx_rdy = rdy;
    endtask

    task automatic setFields();
        for (int c = 0; c < N; c++) begin
            chn_arid[c]    = IW'(c + 3);
            chn_araddr[c]  = AW'(32'h100 * (c + 1));
            chn_arlen[c]   = LW'(c);
            chn_arburst[c] = 2'd1;
        end
    endtask

    task automatic randomFields();
        for (int c = 0; c < N; c++) begin
            chn_arid[c]    = IW'($urandom);
            chn_araddr[c]  = AW'($urandom);
            chn_arlen[c]   = LW'($urandom);
            chn_arburst[c] = 2'($urandom);
        end
    endtask

    // Model and per-cycle compare: check registered outputs and the grant
    // against the model, then advance the model to the next cycle.
    always @(negedge clk) begin
        int g;
        bit ld;
        int c;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) mOstd[k] = 0;
            mGbl = 0; mRr = 0; mVld = 0; mErr = 0; mChn = 0;
            mId = '0; mAddr = '0; mLen = '0; mBurst = '0;
            checkOutput("rst_atx_vld", 64'(atx_vld), 64'd0);
            checkOutput("rst_atx_fields", {atx_chn_id, atx_arid, atx_araddr, atx_arlen, atx_arburst}, 64'd0);
            checkOutput("rst_chn_idle", 64'(packIdle()), 64'hF);
            checkOutput("rst_chn_ar_rdy", 64'(packRdy()), 64'd0);
            checkOutput("rst_ostd_err", 64'(ostd_err), 64'd0);
        end else begin
            checkOutput("atx_vld", 64'(atx_vld), 64'(mVld));
            if (mVld) begin
                checkOutput("atx_chn_id", 64'(atx_chn_id), 64'(mChn));
                checkOutput("atx_arid", 64'(atx_arid), 64'(mId));
                checkOutput("atx_araddr", 64'(atx_araddr), 64'(mAddr));
                checkOutput("atx_arlen", 64'(atx_arlen), 64'(mLen));
                checkOutput("atx_arburst", 64'(atx_arburst), 64'(mBurst));
            end
            checkOutput("ostd_err", 64'(ostd_err), 64'(mErr));
            for (int k = 0; k < N; k++) begin
                checkOutput($sformatf("chn_idle[%0d]", k), 64'(chn_idle[k]), 64'(mOstd[k] == 0));
            end
            ld = !mVld || atx_rdy;
            g  = -1;
            if (ld && mGbl < GOST) begin
                for (int k = 0; k < N; k++) begin
                    c = (mRr + k) % N;
                    if (g < 0 && chn_ar_vld[c] && mOstd[c] < COST) g = c;
                end
            end
            for (int k = 0; k < N; k++) begin
                checkOutput($sformatf("chn_ar_rdy[%0d]", k), 64'(chn_ar_rdy[k]), 64'(g == k));
            end
            for (int k = 0; k < N; k++) begin
                if (chn_cpl[k]) begin
                    if (mOstd[k] == 0) mErr = 1;
                    else begin
                        mOstd[k]--;
                        mGbl--;
                    end
                end
            end
            if (g >= 0) begin
                mOstd[g]++;
                mGbl++;
                mRr    = (g + 1) % N;
                mVld   = 1;
                mChn   = g;
                mId    = chn_arid[g];
                mAddr  = chn_araddr[g];
                mLen   = chn_arlen[g];
                mBurst = chn_arburst[g];
            end else if (ld) begin
                mVld = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int cnt;
        logic [N-1:0] rv;
        logic [N-1:0] rc;
        for (int c = 0; c < N; c++) begin
            chn_ar_vld[c] = 1'b0;
            chn_cpl[c]    = 1'b0;
        end
        setFields();

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        checkOutput("lit_rst_vld", 64'(atx_vld), 64'd0);
        checkOutput("lit_rst_idle", 64'(packIdle()), 64'hF);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] all channels requesting");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'hF, 4'h0, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("lit_seq_rdy%0d", i), 64'(packRdy()), (i < 4) ? 64'(4'b0001 << i) : 64'd0);
            checkOutput($sformatf("lit_seq_vld%0d", i), 64'(atx_vld), 64'(i >= 1 && i <= 4));
            if (i >= 1 && i <= 4) checkOutput($sformatf("lit_seq_id%0d", i), 64'(atx_chn_id), 64'(i - 1));
        end
        applyStimulus(4'h0, 4'hF, 1'b1);
        applyStimulus(4'h0, 4'h0, 1'b1);

        $display("[TB] per-channel limit on channel 1");
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0010, 4'h0, 1'b1);
            @(negedge clk);
            if (chn_ar_rdy[1]) cnt++;
        end
        checkOutput("lit_ch1_grants", 64'(cnt), 64'd2);
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        @(negedge clk);
        checkOutput("lit_cpl_same_cycle", 64'(chn_ar_rdy[1]), 64'd0);
        applyStimulus(4'b0010, 4'h0, 1'b1);
        @(negedge clk);
        checkOutput("lit_cpl_next_cycle", 64'(chn_ar_rdy[1]), 64'd1);
        applyStimulus(4'h0, 4'b0010, 1'b1);
        applyStimulus(4'h0, 4'b0010, 1'b1);
        applyStimulus(4'h0, 4'h0, 1'b1);
        @(negedge clk);
        checkOutput("lit_ch1_idle", 64'(chn_idle[1]), 64'd1);

        $display("[TB] host stall");
        chn_araddr[0] = 32'h1000;
        chn_arlen[0]  = 8'd15;
        applyStimulus(4'b0001, 4'h0, 1'b0);
        @(negedge clk);
        checkOutput("lit_stall_grant0", 64'(packRdy()), 64'b0001);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0100, 4'h0, 1'b0);
            @(negedge clk);
            checkOutput("lit_stall_rdy", 64'(packRdy()), 64'd0);
            checkOutput("lit_stall_addr", 64'(atx_araddr), 64'h1000);
            checkOutput("lit_stall_len", 64'(atx_arlen), 64'd15);
            checkOutput("lit_stall_vld", 64'(atx_vld), 64'd1);
        end
        applyStimulus(4'b0100, 4'h0, 1'b1);
        @(negedge clk);
        checkOutput("lit_release_grant2", 64'(packRdy()), 64'b0100);
        applyStimulus(4'h0, 4'h0, 1'b1);
        @(negedge clk);
        checkOutput("lit_release_addr", 64'(atx_araddr), 64'h300);
        checkOutput("lit_release_chn", 64'(atx_chn_id), 64'd2);
        applyStimulus(4'h0, 4'b0001, 1'b1);

        $display("[TB] grant and completion together on channel 2");
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        @(negedge clk);
        checkOutput("lit_gc_rdy2", 64'(chn_ar_rdy[2]), 64'd1);
        applyStimulus(4'h0, 4'h0, 1'b1);
        @(negedge clk);
        checkOutput("lit_gc_idle2", 64'(chn_idle[2]), 64'd0);
        checkOutput("lit_gc_model_ostd2", 64'(mOstd[2]), 64'd1);
        applyStimulus(4'h0, 4'b0100, 1'b1);
        applyStimulus(4'h0, 4'h0, 1'b1);
        @(negedge clk);
        checkOutput("lit_gc_idle2_end", 64'(chn_idle[2]), 64'd1);

        $display("[TB] completion with nothing outstanding");
        applyStimulus(4'h0, 4'b1000, 1'b1);
        @(negedge clk);
        checkOutput("lit_err_before", 64'(ostd_err), 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'h0, 4'h0, 1'b1);
            @(negedge clk);
            checkOutput("lit_err_sticky", 64'(ostd_err), 64'd1);
            checkOutput("lit_err_idle", 64'(packIdle()), 64'hF);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            randomFields();
            rv = N'($urandom);
            rc = '0;
            for (int c = 0; c < N; c++) begin
                if (mOstd[c] > 0 && $urandom_range(0, 3) == 0) rc[c] = 1'b1;
                if (mOstd[c] == 0 && $urandom_range(0, 199) == 0) rc[c] = 1'b1;
                chn_ar_vld[c] = rv[c];
                chn_cpl[c]    = rc[c];
            end
            atx_rdy = ($urandom_range(0, 3) != 0);
        end

        $display("[TB] reset with transactions outstanding");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int c = 0; c < N; c++) begin
            chn_ar_vld[c] = 1'b0;
            chn_cpl[c]    = 1'b0;
        end
        setFields();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(4'hF, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'h0, 1'b0);
        @(negedge clk);
        checkOutput("lit_pre_rst_vld", 64'(atx_vld), 64'd1);
        checkOutput("lit_pre_rst_idle", 64'(packIdle()), 64'b1000);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("lit_mid_rst_vld", 64'(atx_vld), 64'd0);
        checkOutput("lit_mid_rst_idle", 64'(packIdle()), 64'hF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) chn_ar_vld[c] = 1'b1;
        atx_rdy = 1'b1;
        @(negedge clk);
        checkOutput("lit_post_rst_grant", 64'(packRdy()), 64'b0001);
        applyStimulus(4'h0, 4'h0, 1'b1);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
